mem_access_stage: RTL and testbench

- Memory stage directly downstream of the execute stage. Consumes the ALU result as the address and the execute-stage store data.
- Runs a req/ack handshake with a variable-latency 16-bit data memory and stalls upstream while an access is outstanding.
- Delivers a registered result (load data or pass-through ALU result) to writeback, with an error flag for unaligned or timed-out accesses.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_timeout_ctr.sv | 33 +++
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reserved for a future multi-bit error report; the current stage exports a single flag.
  localparam logic [1:0] ERR_UNALIGNED = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating 8-bit cycle counter with a terminal-count flag at TIMEOUT-1.
// Latency: clear/increment take effect at the next edge; o_tc is combinational from the count.
// Backpressure: none; i_clr has priority over i_en.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // Count BUSY cycles; hold at all-ones so a stuck access never wraps back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues req/ack accesses to data memory, returns load data or ALU pass-through.
// Latency: 1 edge for non-memory/unaligned ops; 3 edges minimum for memory accesses.
// Backpressure: stall (combinational) holds upstream while an access is outstanding; no writeback backpressure.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_rd,
  input  logic              in_wr,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  state_t              r_state, w_state;
  logic                r_mem_req, w_mem_req;
  logic                r_mem_wr, w_mem_wr;
  logic [DATA_W-1:0]   r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
  logic [DATA_W-1:0]   r_result, w_result;
  logic                r_err, w_err;
  logic                r_out_valid, w_out_valid;
  logic [DATA_W-1:0]   r_out_data, w_out_data;
  logic                r_out_err, w_out_err;
  logic                w_stall;
  logic                w_access;
  logic                w_ack;
  logic                w_tc;

  assign w_access = in_valid & (in_rd | in_wr);
  // An ack only counts while a request is actually outstanding.
  assign w_ack    = mem_ack & r_mem_req;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == IDLE),
    .i_en  (r_state == BUSY),
    .o_tc  (w_tc)
  );

  // Next-state, request and result logic; ack beats timeout when both occur together.
  always_comb begin
    w_state     = r_state;
    w_mem_req   = r_mem_req;
    w_mem_wr    = r_mem_wr;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_result    = r_result;
    w_err       = r_err;
    w_out_valid = 1'b0;
    w_out_data  = r_out_data;
    w_out_err   = r_out_err;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access && !in_addr[0]) begin
          w_stall     = 1'b1;
          w_state     = BUSY;
          w_mem_req   = 1'b1;
          w_mem_wr    = in_wr & ~in_rd;
          w_mem_addr  = in_addr;
          w_mem_wdata = in_wdata;
        end else if (in_valid) begin
          // Non-memory op passes through; an unaligned access is flagged without touching memory.
          w_out_valid = 1'b1;
          w_out_data  = in_addr;
          w_out_err   = w_access;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (w_ack) begin
          w_mem_req = 1'b0;
          w_result  = r_mem_wr ? in_addr : mem_rdata;
          w_err     = 1'b0;
          w_state   = DONE;
        end else if (w_tc) begin
          w_mem_req = 1'b0;
          w_result  = in_addr;
          w_err     = 1'b1;
          w_state   = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_out_data  = r_result;
        w_out_err   = r_err;
        w_state     = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State, memory-interface and writeback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_mem_req   <= w_mem_req;
      r_mem_wr    <= w_mem_wr;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_result    <= w_result;
      r_err       <= w_err;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_err   <= w_out_err;
    end
  end

  assign stall     = w_stall;
  assign mem_req   = r_mem_req;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a per-cycle transaction-timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_stage;

  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_rd, in_wr;
  logic [DW-1:0] in_addr, in_wdata;
  logic          stall;
  logic          mem_req, mem_wr;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_err;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_rd     (in_rd),
    .in_wr     (in_wr),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  logic chk_en;

  // Expected values for the current cycle, and the writeback value scheduled for the next one.
  logic          exp_stall, exp_req, exp_wr, exp_ov, exp_oe;
  logic [DW-1:0] exp_addr, exp_wdata, exp_od;
  logic          s_ov, s_oe;
  logic [DW-1:0] s_od;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One model cycle: publish expectations, advance past the next edge, schedule writeback.
  task automatic step(input logic e_stall, input logic e_req, input logic e_wr,
                      input logic [DW-1:0] e_addr, input logic [DW-1:0] e_wdata,
                      input logic n_ov, input logic [DW-1:0] n_od, input logic n_oe);
    exp_stall = e_stall;
    exp_req   = e_req;
    exp_wr    = e_wr;
    exp_addr  = e_addr;
    exp_wdata = e_wdata;
    exp_ov    = s_ov;
    exp_od    = s_od;
    exp_oe    = s_oe;
    @(posedge clk);
    #1;
    s_ov = n_ov;
    s_od = n_od;
    s_oe = n_oe;
  endtask

  // Whole-transaction timeline: ack_at = BUSY cycle (1-based) carrying mem_ack, 0 = never.
  task automatic txn(input logic v, input logic rd, input logic wr,
                     input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [DW-1:0] rdata, input int ack_at);
    logic          acc, hit;
    int            blen;
    logic [DW-1:0] res;
    acc = v & (rd | wr);
    in_valid = v; in_rd = rd; in_wr = wr; in_addr = addr; in_wdata = wdata;
    if (!acc || addr[0]) begin
      step(1'b0, 1'b0, 1'b0, '0, '0, v, addr, acc);
    end else begin
      hit  = (ack_at >= 1) && (ack_at <= TO);
      blen = hit ? ack_at : TO;
      res  = (hit && rd) ? rdata : addr;
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      for (int b = 1; b <= blen; b++) begin
        mem_ack   = (b == ack_at);
        mem_rdata = (b == ack_at) ? rdata : 16'hDEAD;
        step(1'b1, 1'b1, wr & ~rd, addr, wdata, 1'b0, '0, 1'b0);
      end
      mem_ack = 1'b0;
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, res, ~hit);
    end
    in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) txn(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0);
  endtask

  initial begin
    int s0, r0;
    chk_en = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0; in_addr = '0; in_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    s_ov = 1'b0; s_od = '0; s_oe = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_ov = 1'b0; exp_od = '0; exp_oe = 1'b0;

    // Per-cycle compare against the model, sampled on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (stall) stall_cnt++;
        if (mem_req) req_cnt++;
        if (chk_en) begin
          check1("stall", stall, exp_stall);
          check1("mem_req", mem_req, exp_req);
          check1("out_valid", out_valid, exp_ov);
          if (exp_req) begin
            check1("mem_wr", mem_wr, exp_wr);
            check16("mem_addr", mem_addr, exp_addr);
            check16("mem_wdata", mem_wdata, exp_wdata);
          end
          if (exp_ov) begin
            check16("out_data", out_data, exp_od);
            check1("out_err", out_err, exp_oe);
          end
        end
      end
    join_none

    #2;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_mem_wr", mem_wr, 1'b0);
    check16("rst_mem_addr", mem_addr, 16'h0000);
    check16("rst_mem_wdata", mem_wdata, 16'h0000);
    check1("rst_out_valid", out_valid, 1'b0);
    check16("rst_out_data", out_data, 16'h0000);
    check1("rst_out_err", out_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Non-memory pass-through.
    txn(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0);
    check1("nonmem_ov", out_valid, 1'b1);
    check16("nonmem_data", out_data, 16'h1234);
    idle(1);

    // Load, ack in third BUSY cycle.
    s0 = stall_cnt;
    txn(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3);
    check16("load_stall_cycles", 16'(stall_cnt - s0), 16'd4);
    check16("load_data", out_data, 16'hBEEF);
    idle(1);

    // Store, immediate ack: result three edges after presentation.
    txn(1'b1, 1'b0, 1'b1, 16'h0102, 16'hA5A5, 16'h7777, 1);
    check1("store_ov", out_valid, 1'b1);
    check16("store_data", out_data, 16'h0102);
    idle(1);

    // Unaligned load.
    r0 = req_cnt;
    txn(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 0);
    check1("unaligned_err", out_err, 1'b1);
    check16("unaligned_no_req", 16'(req_cnt - r0), 16'd0);
    idle(1);

    // Timeout, then stray acks that must be ignored.
    r0 = req_cnt;
    txn(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 0);
    check16("timeout_req_cycles", 16'(req_cnt - r0), 16'd15);
    check1("timeout_err", out_err, 1'b1);
    mem_ack = 1'b1;
    idle(2);
    mem_ack = 1'b0;

    // Ack on the final allowed cycle wins.
    txn(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h1111, 15);
    check1("ack15_err", out_err, 1'b0);
    check16("ack15_data", out_data, 16'h1111);

    // rd and wr together behave as a load; back-to-back after a non-memory op.
    txn(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 0);
    txn(1'b1, 1'b1, 1'b1, 16'h0044, 16'h5555, 16'hCAFE, 2);
    txn(1'b1, 1'b0, 1'b1, 16'h0046, 16'h3C3C, 16'h0000, 4);
    idle(2);

    // Reset in the second BUSY cycle.
    in_valid = 1'b1; in_rd = 1'b1; in_wr = 1'b0; in_addr = 16'h0010; in_wdata = 16'h0000;
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, '0, 1'b0);
    chk_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check1("midrst_mem_req", mem_req, 1'b0);
    check1("midrst_out_valid", out_valid, 1'b0);
    in_valid = 1'b0; in_rd = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    s_ov = 1'b0; s_od = '0; s_oe = 1'b0;
    chk_en = 1'b1;
    idle(1);
    mem_ack = 1'b0;
    txn(1'b1, 1'b0, 1'b0, 16'h4321, 16'h0000, 16'h0000, 0);
    check16("post_rst_data", out_data, 16'h4321);
    idle(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
